// File: rtl/counter_rr_sched.sv
// Round-robin arbiter that shares one down-counter between two requesters.
// Optional macro CNT_PAUSE_EN adds a pause input that freezes the RUN phase.
module counter_rr_sched #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic             req1,
`ifdef CNT_PAUSE_EN
    input  logic             pause,
`endif
    input  logic [WIDTH-1:0] val0,
    input  logic [WIDTH-1:0] val1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             done0,
    output logic             done1,
    output logic             busy,
    output logic [WIDTH-1:0] cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state, state_nxt;
    logic [WIDTH-1:0] cnt_nxt;
    logic             gnt0_nxt, gnt1_nxt;
    logic             done0_nxt, done1_nxt;
    logic             last, last_nxt;
    logic             pick0;
    logic             hold;

`ifdef CNT_PAUSE_EN
    assign hold = pause;
`else
    assign hold = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            gnt0  <= 1'b0;
            gnt1  <= 1'b0;
            done0 <= 1'b0;
            done1 <= 1'b0;
            last  <= 1'b1;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            gnt0  <= gnt0_nxt;
            gnt1  <= gnt1_nxt;
            done0 <= done0_nxt;
            done1 <= done1_nxt;
            last  <= last_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        gnt0_nxt  = gnt0;
        gnt1_nxt  = gnt1;
        done0_nxt = 1'b0;
        done1_nxt = 1'b0;
        last_nxt  = last;
        // On a tie, requester 0 wins only when requester 1 was served last.
        pick0     = req0 && (!req1 || last);
        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    cnt_nxt   = pick0 ? val0 : val1;
                    gnt0_nxt  = pick0;
                    gnt1_nxt  = !pick0;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (!hold) begin
                    if (cnt != '0) begin
                        cnt_nxt = cnt - ONE;
                    end else begin
                        state_nxt = DONE;
                        gnt0_nxt  = 1'b0;
                        gnt1_nxt  = 1'b0;
                        done0_nxt = gnt0;
                        done1_nxt = gnt1;
                        last_nxt  = gnt1;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);

endmodule
